// File: rtl/frame_sequencer.sv
// Per-frame controller: clears FB/ZB, launches geometry, waits for the render
// pipeline to drain, then pulses frame-done and flips the display buffer.
module frame_sequencer #(
  parameter int          FB_DEPTH    = 76800,
  parameter int          ADDR_W      = 17,
  parameter logic [11:0] CLEAR_PIXEL = 12'h000,
  parameter logic [7:0]  CLEAR_Z     = 8'hFF,
  parameter int          IDLE_HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_clear_en,
  input  logic              i_geom_done,
  input  logic              i_pipe_idle,
  output logic              o_geom_start,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_buf_sel,
  output logic              o_err_collision,
  input  logic [ADDR_W-1:0] i_r_fb_addr,
  input  logic              i_r_fb_we,
  input  logic [11:0]       i_r_fb_pixel,
  input  logic [ADDR_W-1:0] i_r_zb_addr,
  input  logic              i_r_zb_we,
  input  logic [7:0]        i_r_zb_data,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic              o_fb_we,
  output logic [11:0]       o_fb_pixel,
  output logic [ADDR_W-1:0] o_zb_addr,
  output logic              o_zb_we,
  output logic [7:0]        o_zb_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LAUNCH, S_RENDER, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [3:0]        HOLD_LAST = 4'(IDLE_HOLD - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [3:0]        r_idle_cnt;
  logic              r_geom_latch;
  logic              r_geom_start;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_buf_sel;
  logic              r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_idle_cnt   <= '0;
      r_geom_latch <= 1'b0;
      r_geom_start <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_geom_start <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_clear_en) begin
              r_state   <= S_CLEAR;
              r_clr_cnt <= '0;
            end else begin
              r_state      <= S_LAUNCH;
              r_geom_start <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          // Rasterizer writes here are dropped; flag them so the host can see it.
          if (i_r_fb_we || i_r_zb_we)
            r_err <= 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state      <= S_LAUNCH;
            r_clr_cnt    <= '0;
            r_geom_start <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_LAUNCH: begin
          if (i_geom_done)
            r_geom_latch <= 1'b1;
          r_state <= S_RENDER;
        end
        S_RENDER: begin
          if (r_geom_latch) begin
            r_state      <= S_DRAIN;
            r_geom_latch <= 1'b0;
            r_idle_cnt   <= '0;
          end else if (i_geom_done) begin
            r_geom_latch <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!i_pipe_idle) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == HOLD_LAST) begin
            r_state      <= S_DONE;
            r_idle_cnt   <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_buf_sel <= ~r_buf_sel;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shared write port: clear engine owns it only while clearing.
  always_comb begin
    o_fb_addr  = i_r_fb_addr;
    o_fb_we    = i_r_fb_we;
    o_fb_pixel = i_r_fb_pixel;
    o_zb_addr  = i_r_zb_addr;
    o_zb_we    = i_r_zb_we;
    o_zb_data  = i_r_zb_data;
    if (r_state == S_CLEAR) begin
      o_fb_addr  = r_clr_cnt;
      o_fb_we    = 1'b1;
      o_fb_pixel = CLEAR_PIXEL;
      o_zb_addr  = r_clr_cnt;
      o_zb_we    = 1'b1;
      o_zb_data  = CLEAR_Z;
    end
  end

  assign o_geom_start    = r_geom_start;
  assign o_busy          = r_busy;
  assign o_frame_done    = r_frame_done;
  assign o_buf_sel       = r_buf_sel;
  assign o_err_collision = r_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: randomized frames checked against a timeline model
// derived from the frame rules (clear length, launch cycle, idle-window drain).
module tb_frame_sequencer;
  localparam int DEPTH = 16;
  localparam int HOLD  = 4;
  localparam int AW    = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, i_start, i_clear_en, i_geom_done, i_pipe_idle;
  logic [AW-1:0] i_r_fb_addr, i_r_zb_addr;
  logic          i_r_fb_we, i_r_zb_we;
  logic [11:0]   i_r_fb_pixel;
  logic [7:0]    i_r_zb_data;
  logic          o_geom_start, o_busy, o_frame_done, o_buf_sel, o_err_collision;
  logic [AW-1:0] o_fb_addr, o_zb_addr;
  logic          o_fb_we, o_zb_we;
  logic [11:0]   o_fb_pixel;
  logic [7:0]    o_zb_data;

  frame_sequencer #(
    .FB_DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_PIXEL(12'h000), .CLEAR_Z(8'hFF),
    .IDLE_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_clear_en(i_clear_en),
    .i_geom_done(i_geom_done), .i_pipe_idle(i_pipe_idle),
    .o_geom_start(o_geom_start), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_buf_sel(o_buf_sel), .o_err_collision(o_err_collision),
    .i_r_fb_addr(i_r_fb_addr), .i_r_fb_we(i_r_fb_we), .i_r_fb_pixel(i_r_fb_pixel),
    .i_r_zb_addr(i_r_zb_addr), .i_r_zb_we(i_r_zb_we), .i_r_zb_data(i_r_zb_data),
    .o_fb_addr(o_fb_addr), .o_fb_we(o_fb_we), .o_fb_pixel(o_fb_pixel),
    .o_zb_addr(o_zb_addr), .o_zb_we(o_zb_we), .o_zb_data(o_zb_data)
  );

  int   checks = 0;
  int   errors = 0;
  bit   exp_buf = 1'b0;
  bit   exp_err = 1'b0;
  logic [11:0] fb_mem [DEPTH];
  logic [7:0]  zb_mem [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rast(input bit allow_we);
    i_r_fb_addr  = AW'($urandom_range(0, DEPTH - 1));
    i_r_zb_addr  = AW'($urandom_range(0, DEPTH - 1));
    i_r_fb_pixel = 12'($urandom);
    i_r_zb_data  = 8'($urandom);
    i_r_fb_we    = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
    i_r_zb_we    = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // One frame; cycle 0 is the IDLE cycle in which start is presented.
  // mode 0: pipe idle from drain entry, 1: 1,1,1,0 then ones, 2: random.
  task automatic run_frame(input bit clr, input int gdel, input int mode,
                           input bit hold, input bit collide);
    int L, P, d, done_c;
    bit pat [64];
    bit ok, inclr;
    logic [AW+AW+41:0] exp_bus, got_bus;
    L = clr ? DEPTH + 1 : 1;
    P = L + gdel;
    d = P + 2;
    for (int i = 0; i < 64; i++)
      pat[i] = (mode == 0) ? 1'b1 : (mode == 1) ? (i != 3) :
               (i >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
    done_c = -1;
    for (int j = HOLD - 1; j < 64 && done_c < 0; j++) begin
      ok = 1'b1;
      for (int m = j - HOLD + 1; m <= j; m++)
        if (!pat[m]) ok = 1'b0;
      if (ok) done_c = d + j + 1;
    end
    for (int a = 0; a < DEPTH; a++) begin
      fb_mem[a] = 12'h555;
      zb_mem[a] = 8'h55;
    end
    for (int c = 0; c <= done_c; c++) begin
      tick();
      inclr       = clr && c >= 1 && c <= DEPTH;
      i_start     = (c == 0 || hold) ? 1'b1 : 1'($urandom_range(0, 1));
      i_clear_en  = (c == 0) ? clr : 1'($urandom_range(0, 1));
      i_geom_done = (c == P) || ((c < L || c >= d) && $urandom_range(0, 3) == 0);
      i_pipe_idle = (c >= d) ? pat[c - d] : 1'($urandom_range(0, 1));
      drive_rast(!inclr);
      if (collide && c == 6) begin
        i_r_fb_we    = 1'b1;
        i_r_fb_addr  = AW'(5);
        i_r_fb_pixel = 12'hABC;
      end
      #1;
      got_bus = {o_fb_addr, o_fb_we, o_fb_pixel, o_zb_addr, o_zb_we, o_zb_data};
      if (inclr)
        exp_bus = {AW'(c - 1), 1'b1, 12'h000, AW'(c - 1), 1'b1, 8'hFF};
      else
        exp_bus = {i_r_fb_addr, i_r_fb_we, i_r_fb_pixel,
                   i_r_zb_addr, i_r_zb_we, i_r_zb_data};
      checks++;
      if (got_bus !== exp_bus) begin
        errors++;
        $display("FAIL write_port cycle %0d got %h want %h", c, got_bus, exp_bus);
      end
      if (inclr && o_fb_we === 1'b1 && o_fb_addr < DEPTH) begin
        fb_mem[o_fb_addr] = o_fb_pixel;
        zb_mem[o_zb_addr] = o_zb_data;
      end
      checks++;
      if (o_geom_start !== (c == L)) begin
        errors++;
        $display("FAIL geom_start cycle %0d got %b want %b", c, o_geom_start, c == L);
      end
      checks++;
      if (o_frame_done !== (c == done_c)) begin
        errors++;
        $display("FAIL frame_done cycle %0d got %b want %b", c, o_frame_done, c == done_c);
      end
      checks++;
      if (o_busy !== (c != 0)) begin
        errors++;
        $display("FAIL busy cycle %0d got %b want %b", c, o_busy, c != 0);
      end
      checks++;
      if (o_buf_sel !== exp_buf) begin
        errors++;
        $display("FAIL buf_sel cycle %0d got %b want %b", c, o_buf_sel, exp_buf);
      end
      checks++;
      if (o_err_collision !== exp_err) begin
        errors++;
        $display("FAIL err_collision cycle %0d got %b want %b", c, o_err_collision, exp_err);
      end
      if (collide && c == 6) exp_err = 1'b1;
      if (clr && c == L) begin
        ok = 1'b1;
        for (int a = 0; a < DEPTH; a++)
          if (fb_mem[a] !== 12'h000 || zb_mem[a] !== 8'hFF) ok = 1'b0;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL clear_contents fb[5] got %h want 000 zb[5] got %h want ff",
                   fb_mem[5], zb_mem[5]);
        end
      end
    end
    exp_buf = ~exp_buf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_clear_en = 1'b0;
    i_geom_done = 1'b0; i_pipe_idle = 1'b0;
    drive_rast(1'b1);
    tick();
    tick();
    drive_rast(1'b1);
    #1;
    checks++;
    if ({o_geom_start, o_busy, o_frame_done, o_buf_sel, o_err_collision} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {o_geom_start, o_busy, o_frame_done, o_buf_sel, o_err_collision});
    end
    checks++;
    if ({o_fb_addr, o_fb_we, o_fb_pixel} !== {i_r_fb_addr, i_r_fb_we, i_r_fb_pixel} ||
        {o_zb_addr, o_zb_we, o_zb_data} !== {i_r_zb_addr, i_r_zb_we, i_r_zb_data}) begin
      errors++;
      $display("FAIL reset_passthru got fb %h/%b zb %h/%b want fb %h/%b zb %h/%b",
               o_fb_addr, o_fb_we, o_zb_addr, o_zb_we,
               i_r_fb_addr, i_r_fb_we, i_r_zb_addr, i_r_zb_we);
    end
    rst_n = 1'b1;
    exp_buf = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_small_frame();   run_frame(1'b1, 10, 0, 1'b0, 1'b0); endtask
  task automatic test_skip_clear();    run_frame(1'b0, 4, 0, 1'b0, 1'b0);  endtask
  task automatic test_drain_glitch();  run_frame(1'b0, 2, 1, 1'b0, 1'b0);  endtask
  task automatic test_collision();     run_frame(1'b1, 3, 0, 1'b0, 1'b1);  endtask

  task automatic test_back_to_back();
    run_frame(1'b1, 3, 0, 1'b1, 1'b0);
    run_frame(1'b0, 0, 2, 1'b1, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 8; k++)
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 8), 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_clear();
    tick();
    i_start = 1'b1; i_clear_en = 1'b1; i_geom_done = 1'b0;
    drive_rast(1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      i_start = 1'b0;
      drive_rast(1'b0);
      if (c == 8) rst_n = 1'b0;
      #1;
      if (c == 8) begin
        checks++;
        if (o_fb_addr !== AW'(7) || o_fb_we !== 1'b1) begin
          errors++;
          $display("FAIL mid_clear_addr got %0d/%b want 7/1", o_fb_addr, o_fb_we);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      rst_n = 1'b1;
      drive_rast(1'b0);
      #1;
      checks++;
      if ({o_busy, o_geom_start, o_frame_done, o_buf_sel, o_err_collision, o_fb_we, o_zb_we}
          !== 7'b0) begin
        errors++;
        $display("FAIL after_reset cycle %0d got %b want 0000000", c,
                 {o_busy, o_geom_start, o_frame_done, o_buf_sel, o_err_collision,
                  o_fb_we, o_zb_we});
      end
    end
    exp_buf = 1'b0;
    exp_err = 1'b0;
    run_frame(1'b1, 1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_skip_clear();
    test_drain_glitch();
    test_back_to_back();
    test_collision();
    test_random_frames();
    test_reset_mid_clear();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame controller between `fpga_top`'s start input and the render pipeline (geometry engine → vertex FIFO → triangle assembler → rasterizer). On each start it clears the frame buffer and Z-buffer, launches the geometry engine, and waits for the pipeline to drain. It then signals frame completion and flips the display-buffer select. It also owns the shared FB/ZB write port, which it grants to its clear engine during clear and to the rasterizer otherwise.

## Interface
- `FB_DEPTH`, default 76800: pixels per buffer (320x240).
- `ADDR_W`, default 17: FB/ZB address width.
- `CLEAR_PIXEL`, default 12'h000: clear colour (4R4G4B).
- `CLEAR_Z`, default 8'hFF: clear depth (far plane).
- `IDLE_HOLD`, default 4: consecutive idle cycles that define "drained", range 1..15.
- `clk` in 1: single clock. All logic runs on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `i_start` in 1: frame request; a level is sampled only in IDLE.
- `i_clear_en` in 1: sampled with `i_start`. 1 means run CLEAR; 0 means skip it.
- `i_geom_done` in 1: one-cycle pulse from the geometry engine after its last vertex.
- `i_pipe_idle` in 1: vertex FIFO empty AND assembler idle AND rasterizer `o_busy`==0.
- `o_geom_start` out 1: one-cycle launch pulse to the geometry engine.
- `o_busy` out 1: high in every state except IDLE.
- `o_frame_done` out 1: one-cycle pulse at frame end.
- `o_buf_sel` out 1: display-buffer select; toggles once per completed frame.
- `o_err_collision` out 1: sticky; set when the rasterizer writes during CLEAR.
- `i_r_fb_addr`/`i_r_fb_we`/`i_r_fb_pixel` in ADDR_W/1/12: rasterizer FB write.
- `i_r_zb_addr`/`i_r_zb_we`/`i_r_zb_data` in ADDR_W/1/8: rasterizer ZB write.
- `o_fb_addr`/`o_fb_we`/`o_fb_pixel` out ADDR_W/1/12: to the FB write port.
- `o_zb_addr`/`o_zb_we`/`o_zb_data` out ADDR_W/1/8: to the ZB write port.

## Operation
- States: IDLE, CLEAR, LAUNCH, RENDER, DRAIN, DONE.
- IDLE:
  - `i_start`=1 with `i_clear_en`=1 → CLEAR, clear counter=0.
  - `i_start`=1 with `i_clear_en`=0 → LAUNCH.
- CLEAR:
  - Each cycle writes `CLEAR_PIXEL` to FB and `CLEAR_Z` to ZB at the counter address. Both `we` are high and both addresses equal the counter.
  - The counter increments every cycle. When the counter equals `FB_DEPTH-1` (last write) → LAUNCH.
- LAUNCH: `o_geom_start`=1 for exactly this cycle → RENDER.
- RENDER: waits for the `i_geom_done` latch → DRAIN.
- DRAIN:
  - Idle counter increments while `i_pipe_idle`=1 and resets to 0 when `i_pipe_idle`=0.
  - On the cycle `i_pipe_idle`=1 with the counter at `IDLE_HOLD-1` → DONE.
- DONE: `o_frame_done`=1 for this cycle. `o_buf_sel` toggles on the exit edge → IDLE.
- `i_geom_done` latch:
  - Set by a pulse in LAUNCH or RENDER.
  - Cleared on entry to DRAIN.
  - Pulses in IDLE, CLEAR, DRAIN or DONE are ignored.
- Write-port mux:
  - In CLEAR, memory outputs come from the clear engine. Rasterizer writes are dropped, and any `i_r_fb_we` or `i_r_zb_we` sets `o_err_collision`.
  - In all other states the outputs are a combinational pass-through of the `i_r_*` signals.
- `o_err_collision` clears only on reset.
- The ZB read port is not routed through this block.
- `i_start` while `o_busy`=1 is ignored and is not queued.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=IDLE.
  - `o_geom_start`, `o_busy`, `o_frame_done`, `o_buf_sel` and `o_err_collision` all 0.
  - Clear counter and idle counter = 0.
  - Memory outputs follow the `i_r_*` pass-through.
- Reset mid-CLEAR aborts the clear immediately. The next `o_fb_we` from the clear engine comes only after a new start.
- Start accepted at edge k:
  - Address 0 is written in cycle k+1.
  - Address `FB_DEPTH-1` is written in cycle k+`FB_DEPTH`.
  - `o_geom_start` is high in cycle k+`FB_DEPTH`+1.
- With `i_clear_en`=0, `o_geom_start` is high in cycle k+1.
- `i_pipe_idle` held high from DRAIN entry: `o_frame_done` is high exactly `IDLE_HOLD` cycles after DRAIN entry.
- Clear throughput is one pixel per cycle, so a 76800-pixel clear takes 76800 cycles.
- Pass-through adds zero latency: in-to-out is combinational and no registers are inserted.

## Test plan
- **Small-buffer frame** (`FB_DEPTH`=16, `IDLE_HOLD`=4; pulse `i_start` with `i_clear_en`=1; `i_geom_done` 10 cycles after launch; `i_pipe_idle`=1 thereafter):
  - Addresses 0..15 are written with 12'h000 and 8'hFF, one per cycle.
  - `o_geom_start` is high in cycle 17.
  - `o_frame_done` pulses 4 cycles after DRAIN entry.
  - `o_buf_sel` goes 0→1.
- **Skip clear** (`i_clear_en`=0): no FB/ZB writes from the clear engine; `o_geom_start` is high one cycle after start.
- **Drain glitch** (`i_pipe_idle` pattern 1,1,1,0,1,1,1,1 in DRAIN): `o_frame_done` fires only after the final four 1s.
- **Busy start** (`i_start` held high through a whole frame): after DONE, a second frame starts immediately from IDLE. No extra `o_geom_start` pulses occur mid-frame.
- **Collision** (rasterizer `i_r_fb_we`=1 at address 5 during CLEAR):
  - The write is dropped, so address 5 still holds `CLEAR_PIXEL`.
  - `o_err_collision`=1 and stays 1 until reset.
- **Reset mid-CLEAR** (`rst_n`=0 at clear address 7):
  - All outputs take their reset values and `o_busy`=0.
  - A following start restarts the clear at address 0.
